reg_writeback: RTL and testbench

- Write-back stage: the writer end of the decode-stage register file write port (RegWrite / write address / write data).
- Latches MEM/WB results in a pipeline register and selects ALU result vs memory data.
- Drives a qualified write toward the register file and supplies WB-to-ID forwarding hits for the Rs/Rt read addresses.

---
 rtl/reg_writeback.sv | 101 ++++++++++
 tb/tb_reg_writeback.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: write-back stage. Latches MEM/WB results, selects ALU vs
// memory data, drives the register file write port and WB-to-ID forwarding.
// Optional feature macro: WB_RETIRE_COUNT_EN (adds outWbRetired counter).
module reg_writeback #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inWbValid,
  input  logic              inWbRegWrite,
  input  logic              inWbMemtoReg,
  input  logic [ADDR_W-1:0] inWbWriteReg,
  input  logic [DATA_W-1:0] inWbAluResult,
  input  logic [DATA_W-1:0] inWbMemData,
  input  logic              inWbStall,
  input  logic              inWbFlush,
  input  logic [ADDR_W-1:0] inFwdRsReg,
  input  logic [ADDR_W-1:0] inFwdRtReg,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] outWbWriteReg,
  output logic [DATA_W-1:0] outWbWriteData,
  output logic              outWbValid,
  output logic              outFwdRsHit,
  output logic              outFwdRtHit,
  output logic [DATA_W-1:0] outFwdData,
  output logic              outWbRangeErr
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]       outWbRetired
`endif
);

  // One extra bit so NUM_REGS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] REG_LIM = NUM_REGS[ADDR_W:0];

  logic              wb_valid;
  logic              wb_rw;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              range_err;
  logic              in_range;
  logic              wr_en;

  // Stage register: reset > flush > stall > load; data is muxed before capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_rw    <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
    end else if (inWbFlush) begin
      wb_valid <= 1'b0;
      wb_rw    <= 1'b0;
    end else if (!inWbStall) begin
      wb_valid <= inWbValid;
      wb_rw    <= inWbRegWrite;
      wb_reg   <= inWbWriteReg;
      wb_data  <= inWbMemtoReg ? inWbMemData : inWbAluResult;
    end
  end

  // Sticky error once a qualified write to a nonexistent register is dropped.
  always_ff @(posedge clk) begin
    if (reset)
      range_err <= 1'b0;
    else if (wb_valid && wb_rw && !in_range)
      range_err <= 1'b1;
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retired;

  // Count retiring cycles; a stalled instruction is counted only when it leaves.
  always_ff @(posedge clk) begin
    if (reset)
      retired <= '0;
    else if (wb_valid && !inWbStall && !inWbFlush)
      retired <= retired + 32'd1;
  end

  assign outWbRetired = retired;
`endif

  // Write qualification and forwarding compare, combinational from the stage.
  always_comb begin
    in_range    = ({1'b0, wb_reg} < REG_LIM);
    wr_en       = wb_valid & wb_rw & (wb_reg != '0) & in_range;
    outFwdRsHit = wr_en & (inFwdRsReg == wb_reg);
    outFwdRtHit = wr_en & (inFwdRtReg == wb_reg);
  end

  assign RegWrite       = wr_en;
  assign outWbWriteReg  = wb_reg;
  assign outWbWriteData = wb_data;
  assign outWbValid     = wb_valid;
  assign outFwdData     = wb_data;
  assign outWbRangeErr  = range_err;

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: scoreboard bench for reg_writeback. A reference model
// pushes the expected post-edge outputs; they are popped and compared after
// each edge. Build with WB_RETIRE_COUNT_EN to also check the retire counter.
module tb_reg_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          reset, v, rw, mtr, stall, flush;
  logic [AW-1:0] wreg, rs, rt;
  logic [DW-1:0] alu, mem;
  logic          RegWrite, o_valid, rs_hit, rt_hit, rerr;
  logic [AW-1:0] o_reg;
  logic [DW-1:0] o_data, f_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0]   o_ret;
`endif

  reg_writeback #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset),
    .inWbValid(v), .inWbRegWrite(rw), .inWbMemtoReg(mtr),
    .inWbWriteReg(wreg), .inWbAluResult(alu), .inWbMemData(mem),
    .inWbStall(stall), .inWbFlush(flush),
    .inFwdRsReg(rs), .inFwdRtReg(rt),
    .RegWrite(RegWrite), .outWbWriteReg(o_reg), .outWbWriteData(o_data),
    .outWbValid(o_valid), .outFwdRsHit(rs_hit), .outFwdRtHit(rt_hit),
    .outFwdData(f_data), .outWbRangeErr(rerr)
`ifdef WB_RETIRE_COUNT_EN
    , .outWbRetired(o_ret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we, valid, rsh, rth, err;
    logic [AW-1:0] wr;
    logic [DW-1:0] data;
    logic [31:0]   ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model state
  logic          m_valid = 0, m_rw = 0, m_err = 0;
  logic [AW-1:0] m_reg = 0;
  logic [DW-1:0] m_data = 0;
  logic [31:0]   m_ret = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, got, want, $time);
    end
  endtask

  // Drive one cycle, advance the model, push expectation, clock, pop and compare.
  task automatic step(input logic r, input logic iv, input logic irw, input logic imtr,
                      input logic [AW-1:0] ireg, input logic [DW-1:0] ialu,
                      input logic [DW-1:0] imem, input logic ist, input logic ifl,
                      input logic [AW-1:0] irs, input logic [AW-1:0] irt);
    exp_t e;
    reset = r; v = iv; rw = irw; mtr = imtr; wreg = ireg; alu = ialu; mem = imem;
    stall = ist; flush = ifl; rs = irs; rt = irt;
    if (r) begin
      m_valid = 0; m_rw = 0; m_reg = 0; m_data = 0; m_err = 0; m_ret = 0;
    end else begin
      if (m_valid && m_rw && int'(m_reg) >= NR) m_err = 1;
      if (m_valid && !ist && !ifl) m_ret = m_ret + 1;
      if (ifl) begin
        m_valid = 0; m_rw = 0;
      end else if (!ist) begin
        m_valid = iv; m_rw = irw; m_reg = ireg; m_data = imtr ? imem : ialu;
      end
    end
    e.we    = m_valid && m_rw && m_reg != 0 && int'(m_reg) < NR;
    e.valid = m_valid;
    e.wr    = m_reg;
    e.data  = m_data;
    e.rsh   = e.we && irs == m_reg;
    e.rth   = e.we && irt == m_reg;
    e.err   = m_err;
    e.ret   = m_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("RegWrite", {31'b0, RegWrite}, {31'b0, e.we});
    chk("valid",    {31'b0, o_valid},  {31'b0, e.valid});
    chk("wreg",     {27'b0, o_reg},    {27'b0, e.wr});
    chk("wdata",    o_data,            e.data);
    chk("fwddata",  f_data,            e.data);
    chk("rs_hit",   {31'b0, rs_hit},   {31'b0, e.rsh});
    chk("rt_hit",   {31'b0, rt_hit},   {31'b0, e.rth});
    chk("rangeerr", {31'b0, rerr},     {31'b0, e.err});
`ifdef WB_RETIRE_COUNT_EN
    chk("retired",  o_ret,             e.ret);
`endif
  endtask

  task automatic load(input logic [AW-1:0] r, input logic [DW-1:0] d);
    step(0, 1, 1, 0, r, d, 32'h0, 0, 0, r, 5'd0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0);
  endtask

  initial begin
    // reset: every output 0
    step(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0);
    step(1, 1, 1, 1, 5'd9, 32'h5, 32'h6, 0, 0, 5'd9, 5'd9);

    // simple ALU write to reg 5, then idle
    load(5'd5, 32'h0000002A);
    idle();

    // memory data select with forwarding hit on Rs only
    step(0, 1, 1, 1, 5'd3, 32'h1, 32'hDEADBEEF, 0, 0, 5'd3, 5'd4);
    // Rt hit, Rs miss
    step(0, 1, 1, 0, 5'd4, 32'h77, 32'h0, 0, 0, 5'd3, 5'd4);

    // reg 0: dropped silently
    step(0, 1, 1, 0, 5'd0, 32'h99, 32'h0, 0, 0, 5'd0, 5'd0);
    idle();
    // last in-range register, then valid without regwrite
    load(5'd15, 32'h15);
    step(0, 1, 0, 0, 5'd6, 32'h66, 32'h0, 0, 0, 5'd6, 5'd6);

    // out of range: error sets next edge and sticks
    load(5'd20, 32'h20);
    load(5'd16, 32'h16);
    load(5'd9, 32'h9);
    idle();
    idle();

    // load then stall 3 cycles with different inputs, then flush+stall
    load(5'd7, 32'h10);
    repeat (3) step(0, 1, 1, 0, 5'd8, 32'h20, 32'h0, 1, 0, 5'd7, 5'd8);
    step(0, 1, 1, 0, 5'd8, 32'h20, 32'h0, 1, 1, 5'd7, 5'd8);
    idle();

    // reset clears the sticky error
    step(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 5'd0, 5'd0);

    // 4 back-to-back loads, second held 2 cycles, then reset mid-stream
    load(5'd1, 32'hA1);
    load(5'd2, 32'hA2);
    repeat (2) step(0, 1, 1, 0, 5'd3, 32'hA3, 32'h0, 1, 0, 5'd2, 5'd0);
    load(5'd3, 32'hA3);
    load(5'd4, 32'hA4);
    idle();
    load(5'd5, 32'hA5);
    step(1, 1, 1, 0, 5'd6, 32'hA6, 32'h0, 0, 0, 5'd5, 5'd6);
    idle();

    // random traffic
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom, $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
